led_status_arbiter: RTL and testbench

- Shares one board status LED among NUM_REQ requesters (heartbeat, fault, link, config).
- Each requester asks for a blink pattern. Fixed priority chooses the winner, with a minimum hold time so the display does not flicker between requesters.
- Generates the LED waveform from an internal tick prescaler. Replaces fixed free-running blinkers on the top-level status LED.

---
 rtl/led_status_arbiter_if.sv | 15 +
 rtl/led_status_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_led_status_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/led_status_arbiter_if.sv
// Request/grant bundle between the status-LED requesters and the LED arbiter.
// The master drives requests and patterns; the slave (arbiter) returns grant and LED drive.
interface led_status_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [2*NUM_REQ-1:0] mode;
  logic [4*NUM_REQ-1:0] code_cnt;
  logic [NUM_REQ-1:0]   grant;
  logic                 led;
  logic                 busy;

  modport master (output req, mode, code_cnt, input grant, led, busy);
  modport slave  (input req, mode, code_cnt, output grant, led, busy);
endinterface

// File: rtl/led_status_arbiter.sv
// Fixed-priority owner of the board status LED: holds a grant for a minimum time,
// then plays the owner's solid, blink or blink-code pattern from a tick prescaler.
module led_status_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TICK_DIV       = 4999999,
  parameter int MIN_HOLD_TICKS = 10,
  parameter int SLOW_TICKS     = 5,
  parameter int GAP_TICKS      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  led_status_arbiter_if.slave  bus
);

  localparam int PW  = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int HW  = $clog2(MIN_HOLD_TICKS + 2);
  localparam int PHW = $clog2(((SLOW_TICKS > GAP_TICKS) ? SLOW_TICKS : GAP_TICKS) + 1);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV);
  localparam logic [HW-1:0]  HOLD_MAX   = HW'(MIN_HOLD_TICKS);
  localparam logic [PHW-1:0] SLOW_LAST  = PHW'(SLOW_TICKS - 1);
  localparam logic [PHW-1:0] GAP_LAST   = PHW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN_SOLID,
    RUN_BLINK,
    CODE_ON,
    CODE_OFF,
    CODE_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               led_q, led_d;
  logic               busy_q, busy_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [PHW-1:0]     phase_q, phase_d;
  logic [3:0]         burst_q, burst_d;
  logic [1:0]         mode_q, mode_d;
  logic [3:0]         code_q, code_d;

  logic [NUM_REQ-1:0] win_oh;
  logic               win_any;
  logic [1:0]         win_mode;
  logic [3:0]         win_code;

  logic               tick;
  logic [HW-1:0]      hold_inc;
  logic               owner_kept;
  logic               burst_end_ok;
  logic               preempt;
  logic               start;

  // Lowest asserted index wins; scanning downwards lets the lowest overwrite the rest.
  always_comb begin
    win_oh   = '0;
    win_mode = 2'b00;
    win_code = 4'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_mode  = bus.mode[2*i +: 2];
        win_code  = bus.code_cnt[4*i +: 4];
      end
    end
    win_any = |bus.req;
  end

  assign tick       = (state_q != IDLE) && (presc_q == PRESC_LAST);
  assign hold_inc   = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
  assign owner_kept = |(grant_q & bus.req);

  // A blink-code owner yields only on the last gap tick so a burst is never cut short.
  assign burst_end_ok = (mode_q != 2'b11) || ((state_q == CODE_GAP) && (phase_q == GAP_LAST));
  assign preempt      = (state_q != IDLE) && owner_kept && tick && (hold_inc == HOLD_MAX)
                        && burst_end_ok && (win_oh != grant_q);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    led_d   = led_q;
    presc_d = presc_q;
    hold_d  = hold_q;
    phase_d = phase_q;
    burst_d = burst_q;
    mode_d  = mode_q;
    code_d  = code_q;
    start   = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        hold_d  = '0;
      end
      RUN_SOLID: led_d = 1'b1;
      RUN_BLINK: begin
        if (tick) begin
          if (mode_q == 2'b10 || phase_q == SLOW_LAST) begin
            led_d   = ~led_q;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      CODE_ON: begin
        if (tick) begin
          state_d = CODE_OFF;
          led_d   = 1'b0;
        end
      end
      CODE_OFF: begin
        if (tick) begin
          if (burst_q == code_q - 4'd1) begin
            state_d = CODE_GAP;
            burst_d = 4'd0;
            phase_d = '0;
          end else begin
            state_d = CODE_ON;
            burst_d = burst_q + 4'd1;
            led_d   = 1'b1;
          end
        end
      end
      CODE_GAP: begin
        if (tick) begin
          if (phase_q == GAP_LAST) begin
            state_d = CODE_ON;
            led_d   = 1'b1;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) hold_d = hold_inc;
    end

    // Owner drop is resolved before preemption and ignores hold and tick.
    if (state_q == IDLE) begin
      start = win_any;
    end else if (!owner_kept) begin
      if (win_any) begin
        start = 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        led_d   = 1'b0;
        presc_d = '0;
        hold_d  = '0;
        phase_d = '0;
        burst_d = 4'd0;
      end
    end else if (preempt) begin
      start = 1'b1;
    end

    if (start) begin
      grant_d = win_oh;
      led_d   = 1'b1;
      presc_d = '0;
      hold_d  = '0;
      phase_d = '0;
      burst_d = 4'd0;
      mode_d  = win_mode;
      code_d  = (win_code == 4'd0) ? 4'd1 : win_code;
      case (win_mode)
        2'b00:   state_d = RUN_SOLID;
        2'b11:   state_d = CODE_ON;
        default: state_d = RUN_BLINK;
      endcase
    end
  end

  assign busy_d = |grant_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      presc_q <= '0;
      hold_q  <= '0;
      phase_q <= '0;
      burst_q <= 4'd0;
      mode_q  <= 2'b00;
      code_q  <= 4'd1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      phase_q <= phase_d;
      burst_q <= burst_d;
      mode_q  <= mode_d;
      code_q  <= code_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.led   = led_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Scoreboard bench for led_status_arbiter: stimulus queues per-cycle expected
// {grant, led, busy}; a negedge monitor pops and compares independently.
module tb_led_status_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  led_status_arbiter_if #(.NUM_REQ(4)) bus ();

  led_status_arbiter #(
    .NUM_REQ(4), .TICK_DIV(3), .MIN_HOLD_TICKS(2), .SLOW_TICKS(2), .GAP_TICKS(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] grant;
    logic       led;
    logic       busy;
    string      name;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: grant/led/busy got %b want %b", name, act, exp);
  endtask

  task automatic exp_run(input int at, input int len, input logic [3:0] g,
                         input logic l, input logic b, input string name);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.cyc = at + i; e.grant = g; e.led = l; e.busy = b; e.name = name;
      sb.push_back(e);
    end
  endtask

  // Leaves the caller just after the falling edge that follows rising edge c.
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation whose cycle has come due.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          n_total++;
          $display("FAIL %s@%0d: sample missed at cycle %0d", e.name, e.cyc, cyc);
        end else begin
          check($sformatf("%s@%0d", e.name, e.cyc), {bus.grant, bus.led, bus.busy},
                {e.grant, e.led, e.busy});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    reset        = 1'b1;
    bus.req      = 4'b0010;
    bus.mode     = 8'b0000_1000;
    bus.code_cnt = 16'h0000;
    exp_run(1, 2, 4'b0000, 1'b0, 1'b0, "reset_state");

    // Fast blink on req1, granted on the first edge after reset release.
    wait_cyc(2);
    reset = 1'b0;
    g = 3;
    exp_run(g,      4, 4'b0010, 1'b1, 1'b1, "fast_on");
    exp_run(g + 4,  4, 4'b0010, 1'b0, 1'b1, "fast_off");
    exp_run(g + 8,  4, 4'b0010, 1'b1, 1'b1, "fast_on2");
    exp_run(g + 12, 2, 4'b0010, 1'b0, 1'b1, "fast_off2");
    wait_cyc(g + 13);
    bus.req = 4'b0000;
    exp_run(g + 14, 1, 4'b0000, 1'b0, 1'b0, "fast_idle");

    // Blink code 3 on req2; later input changes must be ignored.
    wait_cyc(18);
    bus.mode = 8'b0011_0000; bus.code_cnt = 16'h0300; bus.req = 4'b0100;
    g = 19;
    for (int k = 0; k < 3; k++) begin
      exp_run(g + 8*k,     4, 4'b0100, 1'b1, 1'b1, "code3_on");
      exp_run(g + 8*k + 4, 4, 4'b0100, 1'b0, 1'b1, "code3_off");
    end
    exp_run(g + 24, 8, 4'b0100, 1'b0, 1'b1, "code3_gap");
    exp_run(g + 32, 2, 4'b0100, 1'b1, 1'b1, "code3_repeat");
    wait_cyc(g + 2);
    bus.mode = 8'b0000_0000; bus.code_cnt = 16'h0100;
    wait_cyc(g + 33);
    bus.req = 4'b0000;
    exp_run(g + 34, 1, 4'b0000, 1'b0, 1'b0, "code3_idle");

    // code_cnt 0 behaves as a single blink.
    wait_cyc(54);
    bus.mode = 8'b0011_0000; bus.code_cnt = 16'h0000; bus.req = 4'b0100;
    g = 55;
    exp_run(g,      4, 4'b0100, 1'b1, 1'b1, "code0_on");
    exp_run(g + 4,  4, 4'b0100, 1'b0, 1'b1, "code0_off");
    exp_run(g + 8,  8, 4'b0100, 1'b0, 1'b1, "code0_gap");
    exp_run(g + 16, 2, 4'b0100, 1'b1, 1'b1, "code0_repeat");
    wait_cyc(g + 17);
    bus.req = 4'b0000;
    exp_run(g + 18, 1, 4'b0000, 1'b0, 1'b0, "code0_idle");

    // Slow blink on req2; a lower-priority req3 must not preempt.
    wait_cyc(74);
    bus.mode = 8'b0001_0000; bus.req = 4'b0100;
    g = 75;
    exp_run(g,      8, 4'b0100, 1'b1, 1'b1, "slow_on");
    exp_run(g + 8,  8, 4'b0100, 1'b0, 1'b1, "slow_off");
    exp_run(g + 16, 2, 4'b0100, 1'b1, 1'b1, "slow_on2");
    wait_cyc(g + 2);
    bus.req = 4'b1100;
    wait_cyc(g + 17);
    bus.req = 4'b0000;
    exp_run(g + 18, 1, 4'b0000, 1'b0, 1'b0, "slow_idle");

    // Preemption by req0 once the hold time has elapsed.
    wait_cyc(94);
    bus.req = 4'b0100;
    g = 95;
    exp_run(g,     8, 4'b0100, 1'b1, 1'b1, "hold_owner");
    exp_run(g + 8, 6, 4'b0001, 1'b1, 1'b1, "preempt_solid");
    wait_cyc(g + 1);
    bus.req = 4'b0101;
    wait_cyc(g + 13);
    bus.req = 4'b0000;
    exp_run(g + 14, 1, 4'b0000, 1'b0, 1'b0, "preempt_idle");

    // Blink-code owner req3 yields only at the final gap tick; then owner drops.
    wait_cyc(110);
    bus.mode = 8'b1100_0000; bus.code_cnt = 16'h2000; bus.req = 4'b1000;
    g = 111;
    exp_run(g,      4,  4'b1000, 1'b1, 1'b1, "burst_on");
    exp_run(g + 4,  4,  4'b1000, 1'b0, 1'b1, "burst_off");
    exp_run(g + 8,  4,  4'b1000, 1'b1, 1'b1, "burst_on2");
    exp_run(g + 12, 12, 4'b1000, 1'b0, 1'b1, "burst_off_gap");
    exp_run(g + 24, 4,  4'b0010, 1'b1, 1'b1, "after_gap_grant");
    wait_cyc(g + 5);
    bus.req = 4'b1010;
    wait_cyc(g + 27);
    bus.req = 4'b1000;
    exp_run(g + 28, 4, 4'b1000, 1'b1, 1'b1, "drop_regrant_on");
    exp_run(g + 32, 2, 4'b1000, 1'b0, 1'b1, "drop_regrant_off");
    wait_cyc(g + 33);
    bus.req = 4'b0000;
    exp_run(g + 34, 2, 4'b0000, 1'b0, 1'b0, "drop_idle");

    // Asynchronous reset in the middle of CODE_ON, then re-grant.
    wait_cyc(147);
    bus.mode = 8'b0011_0000; bus.code_cnt = 16'h0300; bus.req = 4'b0100;
    g = 148;
    exp_run(g, 2, 4'b0100, 1'b1, 1'b1, "pre_reset_on");
    wait_cyc(g + 1);
    #2 reset = 1'b1;
    #1 check("async_reset", {bus.grant, bus.led, bus.busy}, 6'b000000);
    wait_cyc(g + 3);
    reset = 1'b0;
    exp_run(g + 4, 2, 4'b0100, 1'b1, 1'b1, "post_reset_grant");
    wait_cyc(g + 6);
    bus.req = 4'b0000;
    exp_run(g + 7, 1, 4'b0000, 1'b0, 1'b0, "final_idle");

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clk);
    #1;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
